// File: rtl/event_arbiter.sv
// event_arbiter
//   Accumulates per-requester event counts and hands out one grant per
//   event.  Each grant consumes one pending event from the chosen requester.
//   Selection is round-robin starting after the last granted index.
//   When EVENT_ARBITER_FIXED_PRIO_EN is defined, selection is fixed priority
//   instead (the lowest eligible index wins).
//
// Parameters
//   NUM_REQ   : number of requesters (2..16)
//   CNT_WIDTH : width of each pending counter and of each delta
//
// Ports
//   clk          : clock; all state updates on the rising edge
//   rst_n        : asynchronous active-low reset
//   req_valid    : bit i set when requester i presents a delta
//   req_delta    : slice i holds the number of events requester i adds
//   req_ready    : bit i set when delta i is accepted this cycle
//                  (combinational, independent of req_valid)
//   grant_valid  : registered; a grant is presented
//   grant_id     : registered; index of the granted requester
//   grant_onehot : registered; one-hot of grant_id, all-zero when idle
//   grant_ready  : downstream consumes the presented grant this cycle
module event_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*CNT_WIDTH-1:0] req_delta,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic [NUM_REQ-1:0]           grant_onehot,
  input  logic                         grant_ready
);

  localparam int          ID_W = $clog2(NUM_REQ);
  localparam int          CW1  = CNT_WIDTH + 1;
  localparam int unsigned NR   = NUM_REQ;

  logic [CNT_WIDTH-1:0] cnt     [NUM_REQ];
  logic [CNT_WIDTH-1:0] cnt_nxt [NUM_REQ];
  logic [CW1-1:0]       sum     [NUM_REQ];
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   issue;
  logic                 slot_free;
  logic                 pick_found;
  logic [ID_W-1:0]      pick_id;

  assign slot_free = !grant_valid || grant_ready;

  always_comb begin
    for (int unsigned i = 0; i < NR; i++) begin
      eligible[i] = (cnt[i] != '0);
    end
  end

`ifdef EVENT_ARBITER_FIXED_PRIO_EN
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (!pick_found && eligible[i]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] last_id;
  int unsigned     rr_idx;

  // Scan last_id+1, last_id+2, ... wrapping at NUM_REQ; first hit wins.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    rr_idx     = 0;
    for (int unsigned k = 1; k <= NR; k++) begin
      rr_idx = (32'(last_id) + k) % NR;
      if (!pick_found && eligible[rr_idx]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(rr_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id <= ID_W'(NUM_REQ - 1);
    end else if (slot_free && pick_found) begin
      last_id <= pick_id;
    end
  end
`endif

  assign issue = (slot_free && pick_found) ? (NUM_REQ'(1) << pick_id) : '0;

  // The extra top bit of sum flags overflow: a delta that would push the
  // counter past its maximum is refused whole rather than truncated.  The
  // issue decrement is folded in, so a full counter being granted this cycle
  // can still take exactly one more event.
  always_comb begin
    for (int unsigned i = 0; i < NR; i++) begin
      sum[i]       = {1'b0, cnt[i]} + {1'b0, req_delta[i*CNT_WIDTH +: CNT_WIDTH]}
                     - CW1'(issue[i]);
      req_ready[i] = !sum[i][CNT_WIDTH];
      cnt_nxt[i]   = (req_valid[i] && req_ready[i]) ? sum[i][CNT_WIDTH-1:0]
                                                    : cnt[i] - CNT_WIDTH'(issue[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NR; i++) begin
        cnt[i] <= '0;
      end
      grant_valid  <= 1'b0;
      grant_id     <= '0;
      grant_onehot <= '0;
    end else begin
      for (int unsigned i = 0; i < NR; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      if (slot_free) begin
        if (pick_found) begin
          grant_valid  <= 1'b1;
          grant_id     <= pick_id;
          grant_onehot <= issue;
        end else begin
          grant_valid  <= 1'b0;
          grant_onehot <= '0;
        end
      end
    end
  end

endmodule
